// File: rtl/pkt_mem_pkg.sv
// Shared types for the packet memory server: request bundle, mode FSM encoding, read-pipe entry.
// The PACKET_SIZE fallback and PACKET_CNTL2SRAM stand in for the project-wide global header.
`ifndef PACKET_SIZE
`define PACKET_SIZE 32
`endif

package pkt_mem_pkg;

  localparam int REQ_ADDR_W = 16;

  // Read request from the packet controller; wide enough to carry out-of-range addresses.
  typedef struct packed {
    logic                  rd_en;
    logic [REQ_ADDR_W-1:0] addr;
  } PACKET_CNTL2SRAM;

  typedef enum logic [2:0] {
    LOAD  = 3'b001,
    SERVE = 3'b010,
    DRAIN = 3'b100
  } pkt_mem_state_e;

  typedef struct packed {
    logic                  valid;
    logic                  oob;
    logic [REQ_ADDR_W-1:0] addr;
  } rd_pipe_t;

  function automatic logic even_parity(input logic [`PACKET_SIZE-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/pkt_mem_array.sv
// Single-port synchronous packet storage: one write or one read per cycle, 1-cycle read data.
module pkt_mem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int W     = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the storage and its read register have no reset; contents must survive a reset and
  // consumers only look at rdata when a valid read is tracked alongside it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/packet_mem_server.sv
// Packet SRAM front-end: LOAD/SERVE/DRAIN mode FSM, fixed-latency read pipe, error/stat counters.
// Optional PKT_MEM_PARITY_EN stores an even-parity bit per word and reports mismatches on read.
`ifndef PACKET_SIZE
`define PACKET_SIZE 32
`endif

module packet_mem_server
  import pkt_mem_pkg::*;
#(
  parameter  int DEPTH  = 256,
  parameter  int RD_LAT = 2,
  parameter  int CNT_W  = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    host_wr_en,
  input  logic [AW-1:0]           host_addr,
  input  logic [`PACKET_SIZE-1:0] host_wdata,
  input  logic                    host_load_done,
  input  logic                    host_reload,
  input  PACKET_CNTL2SRAM         PACKET_CNTL_SRAM_in,
  output logic [`PACKET_SIZE-1:0] Data_SRAM_out,
  output logic                    data_valid,
  output logic                    bank_busy,
  output logic [CNT_W-1:0]        num_packets,
  output logic [CNT_W-1:0]        rd_drop_cnt,
  output logic                    addr_err,
  output logic                    wr_err,
  output logic                    parity_err
);

  localparam int W = `PACKET_SIZE;
`ifdef PKT_MEM_PARITY_EN
  localparam int MEM_W = W + 1;
`else
  localparam int MEM_W = W;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pkt_mem_state_e   state_q, state_d;
  rd_pipe_t         pipe_q [RD_LAT];
  rd_pipe_t         last;
  logic [MEM_W-1:0] arr_wdata, arr_rdata, last_data;
  logic [W-1:0]     ret_data, hold_q;
  logic             rd_oob, wr_oob, rd_accept, wr_accept, pipe_busy;

  assign rd_oob    = 32'(PACKET_CNTL_SRAM_in.addr) >= DEPTH;
  assign wr_oob    = 32'(host_addr) >= DEPTH;
  assign rd_accept = !reset && state_q == SERVE && PACKET_CNTL_SRAM_in.rd_en;
  assign wr_accept = !reset && state_q == LOAD && host_wr_en && !wr_oob;

  pkt_mem_array #(.DEPTH(DEPTH), .AW(AW), .W(MEM_W)) u_array (
    .clk   (clk),
    .we    (wr_accept),
    .re    (rd_accept && !rd_oob),
    .addr  (state_q == LOAD ? host_addr : PACKET_CNTL_SRAM_in.addr[AW-1:0]),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= LOAD;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (host_load_done) state_d = SERVE;
      SERVE:   if (host_reload)    state_d = DRAIN;
      DRAIN:   if (!pipe_busy)     state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Request tracking; the array itself provides the first cycle of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{valid: rd_accept, oob: rd_oob, addr: PACKET_CNTL_SRAM_in.addr};
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < RD_LAT; i++) pipe_busy = pipe_busy | pipe_q[i].valid;
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign last_data = arr_rdata;
    end else begin : g_latn
      logic [MEM_W-1:0] dly_q [RD_LAT-1];
      always_ff @(posedge clk) begin
        dly_q[0] <= arr_rdata;
        for (int k = 1; k < RD_LAT - 1; k++) dly_q[k] <= dly_q[k-1];
      end
      assign last_data = dly_q[RD_LAT-2];
    end
  endgenerate

  assign last          = pipe_q[RD_LAT-1];
  assign ret_data      = last.oob ? '0 : last_data[W-1:0];
  assign data_valid    = last.valid;
  assign Data_SRAM_out = last.valid ? ret_data : hold_q;
  assign bank_busy     = state_q != SERVE;

  always_ff @(posedge clk) begin
    if (reset)           hold_q <= '0;
    else if (last.valid) hold_q <= ret_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num_packets <= '0;
      rd_drop_cnt <= '0;
      addr_err    <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      if (state_q == DRAIN && state_d == LOAD)          num_packets <= '0;
      else if (wr_accept && num_packets != CNT_MAX)     num_packets <= num_packets + CNT_W'(1);
      if (PACKET_CNTL_SRAM_in.rd_en && state_q != SERVE && rd_drop_cnt != CNT_MAX)
        rd_drop_cnt <= rd_drop_cnt + CNT_W'(1);
      if (rd_accept && rd_oob)                          addr_err <= 1'b1;
      if (host_wr_en && (state_q != LOAD || wr_oob))    wr_err <= 1'b1;
    end
  end

`ifdef PKT_MEM_PARITY_EN
  assign arr_wdata = {even_parity(host_wdata), host_wdata};

  always_ff @(posedge clk) begin
    if (reset)                                     parity_err <= 1'b0;
    else if (last.valid && !last.oob && ^last_data) parity_err <= 1'b1;
  end
`else
  assign arr_wdata  = host_wdata;
  assign parity_err = 1'b0;
`endif

endmodule
